// File: rtl/javk_bus_mailbox_pkg.sv
// Register map and bit positions for the JAVK bus mailbox.
package javk_bus_mailbox_pkg;

  localparam logic [1:0] OFF_DATA     = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_CTRL     = 2'd2;
  localparam logic [1:0] OFF_IRQ_MASK = 2'd3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_OVF      = 4;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  function automatic logic [7:0] pack_status(input logic rx_empty, input logic rx_full,
                                             input logic tx_empty, input logic tx_full,
                                             input logic ovf);
    logic [7:0] s;
    s = 8'h00;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_RX_FULL]  = rx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_TX_FULL]  = tx_full;
    s[ST_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/javk_bus_mailbox_fifo.sv
// 8-bit synchronous FIFO with flush; head is visible combinationally (8'h00 when empty).
module javk_bus_mailbox_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  // A pop on empty is a no-op; a push on full is accepted only if a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? 8'h00 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/javk_bus_mailbox.sv
// JAVK CPU-bus mailbox: 4-byte window bridging CPU byte accesses to TX/RX FIFOs.
// Optional feature macro: JAVK_MAILBOX_IRQ_EN (irq output and IRQ_MASK register at offset 3).
module javk_bus_mailbox
  import javk_bus_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef JAVK_MAILBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic       sel, bus_rd, bus_wr;
  logic [1:0] off;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       ctrl_wr, flush, ovf_set, ovf_clr;
  logic       ovf_reg;
  logic [7:0] rx_head, status, rdata;

  assign sel    = (addrbus[15:2] == BASE_ADDR[15:2]);
  assign off    = addrbus[1:0];
  assign bus_rd = sel & rw;
  assign bus_wr = sel & ~rw;

  assign ctrl_wr = bus_wr & (off == OFF_CTRL);
  assign flush   = ctrl_wr & databus[CTRL_FLUSH];
  assign ovf_clr = ctrl_wr & databus[CTRL_CLR_OVF];
  // A write to a full TX FIFO is dropped even if the consumer drains it on the same edge.
  assign ovf_set = bus_wr & (off == OFF_DATA) & tx_full;
  assign tx_push = bus_wr & (off == OFF_DATA) & ~tx_full;
  assign tx_pop  = tx_ready & ~tx_empty;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = bus_rd & (off == OFF_DATA);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  javk_bus_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
    .wdata(databus), .rdata(tx_data), .full(tx_full), .empty(tx_empty)
  );

  javk_bus_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(flush),
    .wdata(rx_data), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst)         ovf_reg <= 1'b0;
    else if (ovf_set) ovf_reg <= 1'b1;
    else if (ovf_clr) ovf_reg <= 1'b0;
  end

  assign status = pack_status(rx_empty, rx_full, tx_empty, tx_full, ovf_reg);

`ifdef JAVK_MAILBOX_IRQ_EN
  logic [4:0] irq_mask_reg;
  logic       irq_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_mask_reg <= 5'd0;
      irq_reg      <= 1'b0;
    end else begin
      if (bus_wr && off == OFF_IRQ_MASK) irq_mask_reg <= databus[4:0];
      irq_reg <= |(status[4:0] & irq_mask_reg);
    end
  end

  assign irq = irq_reg;
`endif

  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_DATA:     rdata = rx_head;
      OFF_STATUS:   rdata = status;
`ifdef JAVK_MAILBOX_IRQ_EN
      OFF_IRQ_MASK: rdata = {3'b000, irq_mask_reg};
`endif
      default:      rdata = 8'h00;
    endcase
  end

  assign databus = bus_rd ? rdata : 8'bz;

endmodule
